instruction_fetch: RTL

Program-counter and instruction-register stage that sits directly upstream of the 256×9 instruction ROM and directly downstream of it. It drives the ROM address, captures the 9-bit word the ROM returns into an instruction register, and hands it to decode through a valid/ready handshake. It also handles branch redirection with flush, decode back-pressure, and a halt state.

---
 rtl/instruction_fetch.sv | 108 ++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter and instruction register stage between the instruction ROM and decode
module instruction_fetch #(
  parameter int                   ANCHO_DIR   = 8,
  parameter int                   ANCHO_INSTR = 9,
  parameter logic [ANCHO_DIR-1:0] PC_INICIAL  = '0
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  output logic [ANCHO_DIR-1:0]   Direccion_Instrucciones,
  input  logic [ANCHO_INSTR-1:0] Instruccion,
  input  logic                   Salto,
  input  logic [ANCHO_DIR-1:0]   Destino_Salto,
  input  logic                   Detener,
  input  logic                   Listo_Decod,
  output logic                   Instr_Valida,
  output logic [ANCHO_INSTR-1:0] Registro_Instr,
  output logic [ANCHO_DIR-1:0]   PC_Instr,
  output logic                   Detenido
);

  typedef enum logic [1:0] {
    INICIO   = 2'd0,
    EJECUTA  = 2'd1,
    DETENIDO = 2'd2
  } estado_t;

  localparam logic [ANCHO_DIR-1:0] UNO = {{(ANCHO_DIR-1){1'b0}}, 1'b1};

  estado_t                estado_q;
  logic [ANCHO_DIR-1:0]   pc_q;
  logic [ANCHO_DIR-1:0]   pc_instr_q;
  logic [ANCHO_INSTR-1:0] ir_q;
  logic                   valida_q;
  logic                   detenido_q;

  // Decode takes the IR on any edge where it is valid and decode is ready;
  // a new word may be captured whenever the IR is empty or being drained.
  logic transferencia;
  logic listo_captura;
  assign transferencia = valida_q && Listo_Decod;
  assign listo_captura = !valida_q || Listo_Decod;

  // Fetch FSM: redirect beats halt, halt beats fetch/stall; all outputs registered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      estado_q   <= INICIO;
      pc_q       <= PC_INICIAL;
      pc_instr_q <= '0;
      ir_q       <= '0;
      valida_q   <= 1'b0;
      detenido_q <= 1'b0;
    end else begin
      case (estado_q)
        INICIO: begin
          // The ROM has not yet seen a stable PC, so nothing is captured here.
          if (Salto) begin
            pc_q <= Destino_Salto;
          end
          estado_q <= EJECUTA;
        end

        EJECUTA: begin
          if (Salto) begin
            // Flush whatever the IR holds; the target word arrives one cycle later.
            pc_q     <= Destino_Salto;
            valida_q <= 1'b0;
          end else if (Detener) begin
            estado_q   <= DETENIDO;
            detenido_q <= 1'b1;
            if (transferencia) begin
              valida_q <= 1'b0;
            end
          end else if (listo_captura) begin
            ir_q       <= Instruccion;
            pc_instr_q <= pc_q;
            valida_q   <= 1'b1;
            pc_q       <= pc_q + UNO;
          end
        end

        DETENIDO: begin
          // Only a redirect (or reset) leaves the halt; the PC stays frozen meanwhile.
          if (Salto) begin
            pc_q       <= Destino_Salto;
            valida_q   <= 1'b0;
            estado_q   <= EJECUTA;
            detenido_q <= 1'b0;
          end else if (transferencia) begin
            valida_q <= 1'b0;
          end
        end

        default: begin
          estado_q   <= INICIO;
          detenido_q <= 1'b0;
          valida_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Direccion_Instrucciones = pc_q;
  assign Instr_Valida            = valida_q;
  assign Registro_Instr          = ir_q;
  assign PC_Instr                = pc_instr_q;
  assign Detenido                = detenido_q;

endmodule
